// File: rtl/ama_riscv_reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ama_riscv_reg_file_mp
// Brief    : Multi-port integer register file with pending-write scoreboard
//            and optional same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 4,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_RD*$clog2(NREGS)-1:0] rd_addr,
   output logic [NUM_RD*XLEN-1:0]      rd_data,
   output logic [NUM_RD-1:0]           rd_busy,
   input  logic [NUM_WR-1:0]           we,
   input  logic [NUM_WR*$clog2(NREGS)-1:0] wr_addr,
   input  logic [NUM_WR*XLEN-1:0]      wr_data,
   input  logic                        iss_valid,
   input  logic [$clog2(NREGS)-1:0]    iss_addr,
   input  logic                        flush
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  rf_q [1:NREGS-1];
   logic [XLEN-1:0]  rf_d [1:NREGS-1];
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;

   // Ascending port order lets the highest-index port win a write conflict;
   // the issue set follows the write clear so the younger producer wins.
   always_comb begin
      for (int r = 1; r < NREGS; r++) begin
         rf_d[r] = rf_q[r];
      end
      busy_d = busy_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (we[p] && (wr_addr[p*AW +: AW] != '0)) begin
            rf_d[wr_addr[p*AW +: AW]]   = wr_data[p*XLEN +: XLEN];
            busy_d[wr_addr[p*AW +: AW]] = 1'b0;
         end
      end
      if (iss_valid && (iss_addr != '0)) begin
         busy_d[iss_addr] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREGS; r++) begin
            rf_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            rf_q[r] <= rf_d[r];
         end
         busy_q <= busy_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [AW-1:0]   w_ra;
         logic            w_hit;
         logic [XLEN-1:0] w_fwd;
         logic [XLEN-1:0] w_data;
         logic            w_busy;

         assign w_ra = rd_addr[i*AW +: AW];

         always_comb begin
            w_hit  = 1'b0;
            w_fwd  = '0;
            w_data = '0;
            w_busy = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
               if (we[p] && (wr_addr[p*AW +: AW] == w_ra)) begin
                  w_hit = 1'b1;
                  w_fwd = wr_data[p*XLEN +: XLEN];
               end
            end
            // Gating on rst_n keeps bypassed write data off the outputs in reset.
            if (!rst_n || (w_ra == '0)) begin
               w_data = '0;
               w_busy = 1'b0;
            end else if ((BYPASS != 0) && w_hit) begin
               w_data = w_fwd;
               w_busy = 1'b0;
            end else begin
               w_data = rf_q[w_ra];
               w_busy = busy_q[w_ra];
            end
         end

         assign rd_data[i*XLEN +: XLEN] = w_data;
         assign rd_busy[i]              = w_busy;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ama_riscv_reg_file_mp
// Brief    : Randomised and directed bench for both bypass variants against
//            an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_reg_file_mp;

   localparam int XLEN = 32, NREGS = 32, AW = 5, NUM_RD = 4, NUM_WR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*XLEN-1:0]   rd_data_b, rd_data_n;
   logic [NUM_RD-1:0]        rd_busy_b, rd_busy_n;
   logic [NUM_WR-1:0]        we;
   logic [NUM_WR*AW-1:0]     wr_addr;
   logic [NUM_WR*XLEN-1:0]   wr_data;
   logic                     iss_valid;
   logic [AW-1:0]            iss_addr;
   logic                     flush;

   int n_checks = 0;
   int n_fail   = 0;

   logic [XLEN-1:0] m_rf   [0:NREGS-1];
   bit              m_busy [0:NREGS-1];

   ama_riscv_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD),
                           .NUM_WR(NUM_WR), .BYPASS(1)) u_dut_byp (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush));

   ama_riscv_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD),
                           .NUM_WR(NUM_WR), .BYPASS(0)) u_dut_nobyp (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
      .rd_busy(rd_busy_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_rf[r]   = '0;
         m_busy[r] = 1'b0;
      end
   endfunction

   function automatic void model_commit();
      logic [AW-1:0] a;
      for (int p = 0; p < NUM_WR; p++) begin
         a = wr_addr[p*AW +: AW];
         if (we[p] && a != 0) begin
            m_rf[a]   = wr_data[p*XLEN +: XLEN];
            m_busy[a] = 1'b0;
         end
      end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
   endfunction

   function automatic void model_read(input bit bp, input int i,
                                      output logic [31:0] d, output logic b);
      logic [AW-1:0] a;
      bit            hit;
      logic [31:0]   fwd;
      a   = rd_addr[i*AW +: AW];
      hit = 1'b0;
      fwd = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (we[p] && wr_addr[p*AW +: AW] == a) begin
            hit = 1'b1;
            fwd = wr_data[p*XLEN +: XLEN];
         end
      end
      if (!rst_n || a == 0) begin
         d = '0; b = 1'b0;
      end else if (bp && hit) begin
         d = fwd; b = 1'b0;
      end else begin
         d = m_rf[a]; b = m_busy[a];
      end
   endfunction

   task automatic check_reads(input string tag);
      logic [31:0] d;
      logic        b;
      for (int i = 0; i < NUM_RD; i++) begin
         model_read(1'b1, i, d, b);
         check($sformatf("%s byp rd%0d data", tag, i), rd_data_b[i*XLEN +: XLEN], d);
         check($sformatf("%s byp rd%0d busy", tag, i), {31'b0, rd_busy_b[i]}, {31'b0, b});
         model_read(1'b0, i, d, b);
         check($sformatf("%s nobyp rd%0d data", tag, i), rd_data_n[i*XLEN +: XLEN], d);
         check($sformatf("%s nobyp rd%0d busy", tag, i), {31'b0, rd_busy_n[i]}, {31'b0, b});
      end
   endtask

   // Inputs are set 1ns after a rising edge; outputs checked 3ns later.
   task automatic cycle(input string tag);
      #3;
      check_reads(tag);
      @(posedge clk);
      if (rst_n) model_commit();
      else       model_reset();
      #1;
   endtask

   task automatic idle();
      we = '0; wr_addr = '0; wr_data = '0;
      iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
   endtask

   task automatic set_rd(input int i, input int a);
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input int a, input logic [31:0] d);
      we[p] = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic reset_mid(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reads(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREGS - 1));
   endfunction

   initial begin
      model_reset();
      rd_addr = '0;
      idle();
      rst_n = 1'b0;

      // Reset held while every port is driven
      set_wr(0, 5, 32'h0BAD_0005);
      set_wr(1, 6, 32'h0BAD_0006);
      iss_valid = 1'b1; iss_addr = 5'd7;
      for (int i = 0; i < NUM_RD; i++) set_rd(i, 5 + i);
      #1;
      for (int k = 0; k < 3; k++) cycle("in_reset");
      check("in_reset rd0 const", rd_data_b[31:0], 32'h0);
      rst_n = 1'b1;
      idle();
      for (int base = 1; base < NREGS; base += NUM_RD) begin
         for (int i = 0; i < NUM_RD; i++) set_rd(i, (base + i < NREGS) ? base + i : 0);
         cycle("post_reset");
      end

      // Basic write/read and x0
      set_wr(0, 5, 32'hDEADBEEF);
      for (int i = 0; i < NUM_RD; i++) set_rd(i, 5);
      cycle("wr_x5");
      idle();
      cycle("rd_x5");
      for (int i = 0; i < NUM_RD; i++)
         check($sformatf("x5 nobyp rd%0d", i), rd_data_n[i*XLEN +: XLEN], 32'hDEADBEEF);
      set_wr(0, 0, 32'h1234);
      set_rd(0, 0);
      cycle("wr_x0");
      idle();
      #1;
      check("x0 readback byp", rd_data_b[31:0], 32'h0);
      check("x0 readback nobyp", rd_data_n[31:0], 32'h0);
      cycle("rd_x0");

      // Write conflict with bypass
      set_wr(0, 7, 32'h11111111);
      set_wr(1, 7, 32'h22222222);
      set_rd(2, 7);
      #1;
      check("conflict byp same cycle", rd_data_b[2*XLEN +: XLEN], 32'h22222222);
      check("conflict nobyp old", rd_data_n[2*XLEN +: XLEN], 32'h0);
      cycle("conflict");
      idle();
      #1;
      check("conflict nobyp next", rd_data_n[2*XLEN +: XLEN], 32'h22222222);
      cycle("conflict_next");

      // Scoreboard set then clear by write
      iss_valid = 1'b1; iss_addr = 5'd9;
      set_rd(0, 9);
      #1;
      check("issue no comb busy", {31'b0, rd_busy_b[0]}, 32'h0);
      cycle("iss_x9");
      idle();
      #1;
      check("x9 busy byp", {31'b0, rd_busy_b[0]}, 32'h1);
      check("x9 busy nobyp", {31'b0, rd_busy_n[0]}, 32'h1);
      cycle("x9_busy");
      set_wr(1, 9, 32'h99);
      #1;
      check("x9 busy bypassed", {31'b0, rd_busy_b[0]}, 32'h0);
      cycle("wr_x9");
      idle();
      #1;
      check("x9 busy cleared", {31'b0, rd_busy_n[0]}, 32'h0);
      cycle("x9_clr");

      // Set/clear collision: set wins
      iss_valid = 1'b1; iss_addr = 5'd3;
      set_wr(0, 3, 32'hA5A5A5A5);
      set_rd(1, 3);
      cycle("collide");
      idle();
      #1;
      check("collide busy", {31'b0, rd_busy_n[1]}, 32'h1);
      check("collide data", rd_data_n[1*XLEN +: XLEN], 32'hA5A5A5A5);
      cycle("collide_next");

      // Issue x1..x3 then flush
      set_wr(0, 1, 32'h0000_0101);
      set_wr(1, 2, 32'h0000_0202);
      cycle("pre_flush_wr");
      idle();
      for (int r = 1; r <= 3; r++) begin
         iss_valid = 1'b1; iss_addr = AW'(r);
         cycle("iss_seq");
      end
      idle();
      flush = 1'b1;
      for (int i = 0; i < 3; i++) set_rd(i, i + 1);
      cycle("flush");
      idle();
      #1;
      check("flush busy x1", {31'b0, rd_busy_n[0]}, 32'h0);
      check("flush data x2", rd_data_n[1*XLEN +: XLEN], 32'h0000_0202);
      check("flush data x3", rd_data_n[2*XLEN +: XLEN], 32'hA5A5A5A5);
      cycle("post_flush");

      // Asynchronous reset mid-cycle
      reset_mid("mid_reset");
      for (int base = 1; base < NREGS; base += NUM_RD) begin
         for (int i = 0; i < NUM_RD; i++) set_rd(i, (base + i < NREGS) ? base + i : 0);
         cycle("after_mid_reset");
      end

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = rnd_addr();
         for (int p = 0; p < NUM_WR; p++) begin
            we[p] = ($urandom_range(0, 2) != 0);
            wr_addr[p*AW +: AW] = rnd_addr();
            wr_data[p*XLEN +: XLEN] = $urandom;
         end
         iss_valid = ($urandom_range(0, 1) == 1);
         iss_addr  = rnd_addr();
         flush     = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) reset_mid("rand_reset");
         else                             cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
